// File: rtl/aes_dec_scheduler.sv
// aes_dec_scheduler
//   Shares one AES decipher core between two requesters. An idle core is granted to a
//   valid requester using round-robin priority. The ciphertext and keylen are latched and
//   held on the core inputs for the whole job. The core is started with a one-cycle next
//   pulse. The plaintext is returned on a single response port, tagged with the requester
//   id. A watchdog aborts any job whose core never returns ready.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   req{0,1}_valid/_ready             request handshake (ready is combinational)
//   req{0,1}_block/_keylen            ciphertext and key length (0=AES-128, 1=AES-256)
//   core_next/_block/_keylen          start pulse and held job inputs to the core
//   core_ready, core_new_block        core idle/done flag and plaintext result
//   rsp_valid/_ready/_block/_id       response handshake, plaintext and requester id
//   busy                              scheduler is not idle
//   wdog_err, wdog_clr                sticky watchdog abort flag and its clear
module aes_dec_scheduler #(
  parameter logic [15:0] WDOG_CYCLES = 16'd200
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_block,
  input  logic         req0_keylen,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_block,
  input  logic         req1_keylen,
  output logic         core_next,
  output logic [127:0] core_block,
  output logic         core_keylen,
  input  logic         core_ready,
  input  logic [127:0] core_new_block,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_block,
  output logic         rsp_id,
  output logic         busy,
  output logic         wdog_err,
  input  logic         wdog_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        last_grant;   // id of the most recently finished (or aborted) job
  logic        job_id;       // id of the job currently in flight
  logic [15:0] wdog_cnt;     // WAIT cycles elapsed for the current job
  logic        grant_id;
  logic        can_grant;
  logic        wait_first;
  logic        wdog_hit;

  // When both requesters are valid, the requester that was not served last wins.
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    can_grant  = (state == IDLE) && core_ready;
    // The core drops ready only on the edge after next. Its ready level in the first
    // WAIT cycle is therefore stale and must not be taken as done.
    wait_first = (wdog_cnt == 16'd0);
    wdog_hit   = ((wdog_cnt + 16'd1) == WDOG_CYCLES);
  end

  assign req0_ready = can_grant && req0_valid && !grant_id;
  assign req1_ready = can_grant && req1_valid && grant_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      job_id      <= 1'b0;
      wdog_cnt    <= 16'd0;
      core_next   <= 1'b0;
      core_block  <= 128'd0;
      core_keylen <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_block   <= 128'd0;
      rsp_id      <= 1'b0;
      wdog_err    <= 1'b0;
    end else begin
      core_next <= 1'b0;
      // The clear is written first so that a watchdog set later in this cycle takes
      // priority over it.
      if (wdog_clr) begin
        wdog_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            core_block  <= grant_id ? req1_block : req0_block;
            core_keylen <= grant_id ? req1_keylen : req0_keylen;
            job_id      <= grant_id;
            // Registered here, so next is high during exactly the START cycle.
            core_next   <= 1'b1;
            state       <= START;
          end
        end

        START: begin
          wdog_cnt <= 16'd0;
          state    <= WAIT;
        end

        WAIT: begin
          wdog_cnt <= wdog_cnt + 16'd1;
          if (core_ready && !wait_first) begin
            rsp_block <= core_new_block;
            rsp_id    <= job_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wdog_hit) begin
            // Drop the job silently. The aborted requester loses the next tie.
            wdog_err   <= 1'b1;
            last_grant <= job_id;
            state      <= IDLE;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= job_id;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
